// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer driving an external saturating down-counter.
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
module traffic_phase_controller #(
    parameter int BIT_WIDTH     = 6,
    parameter int CAR_WIDTH     = 4,
    parameter int GREEN_MIN     = 8,
    parameter int GREEN_PER_CAR = 2,
    parameter int GREEN_MAX     = 30,
    parameter int YELLOW_TIME   = 3,
    parameter int ALL_RED_TIME  = 1,
    parameter int WALK_TIME     = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [CAR_WIDTH-1:0] i_ns_cars,
    input  logic [CAR_WIDTH-1:0] i_ew_cars,
    input  logic                 i_is_zero,
    input  logic                 i_ped_req,
    output logic                 o_load,
    output logic                 o_down,
    output logic [BIT_WIDTH-1:0] o_load_in,
    output logic [2:0]           o_ns_light,
    output logic [2:0]           o_ew_light,
    output logic                 o_walk
);

    localparam int SUM_W = BIT_WIDTH + CAR_WIDTH + 1;
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    typedef enum logic [2:0] {
        ST_NS_G,
        ST_NS_Y,
        ST_RED_TO_EW,
        ST_EW_G,
        ST_EW_Y,
        ST_RED_TO_NS
`ifdef PED_WALK_EN
        , ST_PED
`endif
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_run, w_run_nxt;
    logic                 r_rst;
    logic [BIT_WIDTH-1:0] r_green, w_green_nxt;
`ifdef PED_WALK_EN
    logic                 r_ped, w_ped_nxt;
    logic                 r_ped_to_ew, w_ped_to_ew_nxt;
`else
    logic                 w_unused_ped;
    assign w_unused_ped = i_ped_req;
`endif

    function automatic logic [BIT_WIDTH-1:0] green_time(input logic [CAR_WIDTH-1:0] cars);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(GREEN_MIN) + SUM_W'(cars) * SUM_W'(GREEN_PER_CAR);
        if (sum > SUM_W'(GREEN_MAX))
            return BIT_WIDTH'(GREEN_MAX);
        return sum[BIT_WIDTH-1:0];
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RED_TO_NS;
            r_run       <= 1'b0;
            r_rst       <= 1'b1;
            r_green     <= '0;
`ifdef PED_WALK_EN
            r_ped       <= 1'b0;
            r_ped_to_ew <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_rst       <= 1'b0;
            r_green     <= w_green_nxt;
`ifdef PED_WALK_EN
            r_ped       <= w_ped_nxt;
            r_ped_to_ew <= w_ped_to_ew_nxt;
`endif
        end
    end

    // r_rst holds the LOAD substate through the reset-release cycle; isZero only matters in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_green_nxt = r_green;
`ifdef PED_WALK_EN
        w_ped_to_ew_nxt = r_ped_to_ew;
        w_ped_nxt       = r_ped | i_ped_req;
        if (!r_rst && !r_run && r_state == ST_PED)
            w_ped_nxt = i_ped_req;
`endif
        if (!r_rst) begin
            if (!r_run) begin
                w_run_nxt = 1'b1;
            end else if (i_is_zero) begin
                w_run_nxt = 1'b0;
                case (r_state)
                    ST_NS_G: begin
                        if (i_ew_cars == '0)
                            w_green_nxt = green_time(i_ns_cars);
                        else
                            w_state_nxt = ST_NS_Y;
                    end
                    ST_NS_Y: w_state_nxt = ST_RED_TO_EW;
                    ST_RED_TO_EW: begin
                        w_state_nxt = ST_EW_G;
                        w_green_nxt = green_time(i_ew_cars);
`ifdef PED_WALK_EN
                        if (r_ped) begin
                            w_state_nxt     = ST_PED;
                            w_ped_to_ew_nxt = 1'b1;
                        end
`endif
                    end
                    ST_EW_G: begin
                        if (i_ns_cars == '0)
                            w_green_nxt = green_time(i_ew_cars);
                        else
                            w_state_nxt = ST_EW_Y;
                    end
                    ST_EW_Y: w_state_nxt = ST_RED_TO_NS;
                    ST_RED_TO_NS: begin
                        w_state_nxt = ST_NS_G;
                        w_green_nxt = green_time(i_ns_cars);
`ifdef PED_WALK_EN
                        if (r_ped) begin
                            w_state_nxt     = ST_PED;
                            w_ped_to_ew_nxt = 1'b0;
                        end
`endif
                    end
`ifdef PED_WALK_EN
                    ST_PED: begin
                        if (r_ped_to_ew) begin
                            w_state_nxt = ST_EW_G;
                            w_green_nxt = green_time(i_ew_cars);
                        end else begin
                            w_state_nxt = ST_NS_G;
                            w_green_nxt = green_time(i_ns_cars);
                        end
                    end
`endif
                    default: w_state_nxt = ST_RED_TO_NS;
                endcase
            end
        end
    end

    always_comb begin
        o_load     = 1'b0;
        o_down     = 1'b0;
        o_load_in  = '0;
        o_ns_light = LIGHT_R;
        o_ew_light = LIGHT_R;
        o_walk     = 1'b0;
        if (!r_rst) begin
            o_load = !r_run;
            o_down = r_run;
            case (r_state)
                ST_NS_G: begin
                    o_ns_light = LIGHT_G;
                    o_load_in  = r_green;
                end
                ST_NS_Y: begin
                    o_ns_light = LIGHT_Y;
                    o_load_in  = BIT_WIDTH'(YELLOW_TIME);
                end
                ST_EW_G: begin
                    o_ew_light = LIGHT_G;
                    o_load_in  = r_green;
                end
                ST_EW_Y: begin
                    o_ew_light = LIGHT_Y;
                    o_load_in  = BIT_WIDTH'(YELLOW_TIME);
                end
                ST_RED_TO_EW, ST_RED_TO_NS: o_load_in = BIT_WIDTH'(ALL_RED_TIME);
`ifdef PED_WALK_EN
                ST_PED: begin
                    o_walk    = 1'b1;
                    o_load_in = BIT_WIDTH'(WALK_TIME);
                end
`endif
                default: o_load_in = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: external counter model, phase-schedule reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_traffic_phase_controller;

    localparam int NSG = 0, NSY = 1, REW = 2, EWG = 3, EWY = 4, RNS = 5, PED = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ns_cars, ew_cars;
    logic       ped_req;
    logic       is_zero;
    logic       load, down, walk;
    logic [5:0] load_in;
    logic [2:0] ns_light, ew_light;
    logic [5:0] cnt = 6'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .i_clk(clk), .i_reset(rst), .i_ns_cars(ns_cars), .i_ew_cars(ew_cars),
        .i_is_zero(is_zero), .i_ped_req(ped_req), .o_load(load), .o_down(down),
        .o_load_in(load_in), .o_ns_light(ns_light), .o_ew_light(ew_light), .o_walk(walk)
    );

    // saturating down-counter the controller drives
    always @(posedge clk) begin
        if (load) cnt <= load_in;
        else if (down && cnt != 6'd0) cnt <= cnt - 6'd1;
    end
    assign is_zero = (cnt == 6'd0);

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int green(input int cars);
        int t;
        t = 8 + 2 * cars;
        return (t > 30) ? 30 : t;
    endfunction

    // reference model: phase index, cycle index within dwell, duration of the phase
    bit started = 0;
    bit m_rst = 1;
    bit m_ped = 0;
    int ph = RNS, k = 0, dur = 1, ped_ret = NSG;

    always @(posedge clk) begin
        int old_ph, old_k;
        bit old_ped;
        old_ph = ph; old_k = k; old_ped = m_ped;
        if (rst) begin
            started = 1; m_rst = 1; ph = RNS; k = 0; dur = 1; m_ped = 0;
        end else if (started) begin
            if (m_rst) begin
                m_rst = 0; k = 0;
            end else if (k <= dur) begin
                k++;
            end else begin
                k = 0;
                case (ph)
                    NSG: if (ew_cars == 0) dur = green(ns_cars); else begin ph = NSY; dur = 3; end
                    NSY: begin ph = REW; dur = 1; end
                    REW: if (old_ped) begin ph = PED; ped_ret = EWG; dur = 10; end
                         else begin ph = EWG; dur = green(ew_cars); end
                    EWG: if (ns_cars == 0) dur = green(ew_cars); else begin ph = EWY; dur = 3; end
                    EWY: begin ph = RNS; dur = 1; end
                    RNS: if (old_ped) begin ph = PED; ped_ret = NSG; dur = 10; end
                         else begin ph = NSG; dur = green(ns_cars); end
                    default: begin
                        ph = ped_ret;
                        dur = green(ped_ret == NSG ? int'(ns_cars) : int'(ew_cars));
                    end
                endcase
            end
`ifdef PED_WALK_EN
            if (old_ph == PED && old_k == 0) m_ped = 0;
            if (ped_req) m_ped = 1;
`endif
        end
    end

    always @(negedge clk) begin
        int e_ns, e_ew;
        if (started) begin
            e_ns = (m_rst || ph != NSG && ph != NSY) ? 4 : (ph == NSG ? 1 : 2);
            e_ew = (m_rst || ph != EWG && ph != EWY) ? 4 : (ph == EWG ? 1 : 2);
            chk("load",    int'(load),     m_rst ? 0 : int'(k == 0));
            chk("down",    int'(down),     m_rst ? 0 : int'(k != 0));
            chk("load_in", int'(load_in),  m_rst ? 0 : dur);
            chk("ns_light", int'(ns_light), e_ns);
            chk("ew_light", int'(ew_light), e_ew);
            chk("walk",    int'(walk),     int'(!m_rst && ph == PED));
        end
    end

    task automatic wait_load(input logic [2:0] ns_exp, input logic [2:0] ew_exp, input string name);
        int n;
        n = 0;
        while (!(load && ns_light == ns_exp && ew_light == ew_exp) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic count_ns(input logic [2:0] l, output int n);
        n = 0;
        while (ns_light == l && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1; ns_cars = 4'd3; ew_cars = 4'd2; ped_req = 0;
        // 1: reset and release
        @(negedge clk); @(negedge clk);
        chk("rst_load", int'(load), 0);
        chk("rst_down", int'(down), 0);
        chk("rst_ns", int'(ns_light), 4);
        chk("rst_ew", int'(ew_light), 4);
        rst = 0;
        @(negedge clk);
        chk("rel_load", int'(load), 1);
        chk("rel_load_in", int'(load_in), 1);
        // 2: NS green 14 for 16 cycles, yellow 3 for 5 cycles
        wait_load(3'b001, 3'b100, "ns_g1");
        chk("nsg_load_in", int'(load_in), 14);
        count_ns(3'b001, n);
        chk("nsg_cycles", n, 16);
        chk("nsy_load_in", int'(load_in), 3);
        count_ns(3'b010, n);
        chk("nsy_cycles", n, 5);
        // 3: clamp, then minimum
        ns_cars = 4'd15;
        wait_load(3'b100, 3'b001, "ew_g1");
        chk("ewg_load_in", int'(load_in), 12);
        wait_load(3'b001, 3'b100, "ns_g2");
        chk("nsg_clamp", int'(load_in), 30);
        wait_load(3'b100, 3'b010, "ew_y1");
        ns_cars = 4'd0;
        wait_load(3'b001, 3'b100, "ns_g3");
        chk("nsg_min", int'(load_in), 8);
        // 4: rest in NS green while EW is empty
        ew_cars = 4'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load && n < 20);
        chk("rest_period", n, 10);
        chk("rest_ns", int'(ns_light), 1);
        chk("rest_load_in", int'(load_in), 8);
        ew_cars = 4'd1;
        count_ns(3'b001, n);
        chk("rest_cycles", n, 10);
        chk("rest_then_y", int'(ns_light), 2);
        // 5: reset mid yellow
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_ns", int'(ns_light), 4);
        chk("mid_rst_ew", int'(ew_light), 4);
        chk("mid_rst_load", int'(load), 0);
        rst = 0;
        @(negedge clk);
        chk("mid_rel_load", int'(load), 1);
        chk("mid_rel_load_in", int'(load_in), 1);
        repeat (3) @(negedge clk);
        chk("restart_ns", int'(ns_light), 1);
        chk("restart_load", int'(load), 1);
        chk("restart_load_in", int'(load_in), 8);
        ns_cars = 4'd2;
`ifdef PED_WALK_EN
        // 6: pedestrian request during EW green
        wait_load(3'b100, 3'b001, "ew_g2");
        @(negedge clk);
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        n = 0;
        while (!walk && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("walk_timeout", 0, 1);
        chk("walk_load", int'(load), 1);
        chk("walk_load_in", int'(load_in), 10);
        chk("walk_ns", int'(ns_light), 4);
        n = 0;
        while (walk && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("walk_cycles", n, 12);
        chk("after_walk_ns", int'(ns_light), 1);
        chk("after_walk_load_in", int'(load_in), 12);
`else
        // pedestrian button has no effect without the walk phase
        wait_load(3'b100, 3'b001, "ew_g2");
        ped_req = 1;
        @(negedge clk);
        ped_req = 0;
        wait_load(3'b001, 3'b100, "ns_g4");
        chk("no_walk", int'(walk), 0);
        chk("no_walk_load_in", int'(load_in), 12);
`endif
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
